per_master_arbiter: RTL and testbench
=====================================

// Module: per_master_arbiter
// PURPOSE
//  Round-robin arbiter sharing one peripheral-interconnect master port among
//  NB_MASTERS requesters (e.g. several APB-to-peripheral bridges, debug port).
//  Grants one request at a time and forwards it to the shared port.
//  Writes complete at grant. Reads hold the arbiter until r_valid, and the
//  response goes back to the owning requester.
// PARAMETERS
//  NB_MASTERS  2   number of requesters, >=1
//  ADDR_WIDTH  15  peripheral address width
// PORTS
//  clk_i           in   1              clock
//  rst_ni          in   1              asynchronous active-low reset
//  slv_req_i       in   NB_MASTERS     per-requester request
//  slv_add_i       in   NB*ADDR_WIDTH  addresses, requester i at [i*AW +: AW]
//  slv_we_i        in   NB_MASTERS     1=write, 0=read
//  slv_wdata_i     in   NB*32          write data, requester i at [i*32 +: 32]
//  slv_be_i        in   NB*4           byte enables, requester i at [i*4 +: 4]
//  slv_gnt_o       out  NB_MASTERS     per-requester grant
//  slv_r_valid_o   out  NB_MASTERS     per-requester read response valid
//  slv_r_opc_o     out  1              response opcode (broadcast)
//  slv_r_rdata_o   out  32             response data (broadcast)
//  mst_req_o       out  1              shared port request
//  mst_add_o       out  ADDR_WIDTH     shared port address
//  mst_we_o        out  1              shared port write enable
//  mst_wdata_o     out  32             shared port write data
//  mst_be_o        out  4              shared port byte enables
//  mst_gnt_i       in   1              shared port grant
//  mst_r_valid_i   in   1              shared port response valid
//  mst_r_opc_i     in   1              shared port response opcode
//  mst_r_opc/rdata passthrough: slv_r_opc_o=mst_r_opc_i, slv_r_rdata_o=mst_r_rdata_i
//  mst_r_rdata_i   in   32             shared port response data
// BEHAVIOUR
//  - Registers: state {IDLE,WAIT_RSP}, rr_ptr, lock, lock_idx, rsp_idx.
//    Reset: IDLE, rr_ptr=0, lock=0.
//  - Outputs are combinational from state and inputs. With no request, all
//    mst_* outputs are 0, and all slv_gnt_o and slv_r_valid_o bits are 0.
//    This holds during and after reset.
//  - Requesters hold req and payload stable until gnt. The arbiter holds
//    mst_req_o and payload stable until mst_gnt_i.
//  - IDLE, lock=0: winner = first requester with req set, scanning from
//    rr_ptr upward with wrap at NB_MASTERS. Its payload drives mst_*,
//    mst_req_o=1, and slv_gnt_o[winner]=mst_gnt_i.
//  - IDLE, lock=1: winner=lock_idx regardless of other requests.
//  - Winner set and mst_gnt_i=0: lock<=1, lock_idx<=winner. No other
//    requester can preempt.
//  - Handshake (mst_req_o & mst_gnt_i): lock<=0,
//    rr_ptr<=(winner+1) mod NB_MASTERS.
//    Write: stay IDLE, so a new arbitration happens next cycle.
//    Read: rsp_idx<=winner, go to WAIT_RSP.
//  - WAIT_RSP: mst_req_o=0, all slv_gnt_o=0, new requests wait.
//    On mst_r_valid_i: slv_r_valid_o[rsp_idx]=1 in the same cycle, go to IDLE.
//    There is no grant in that cycle; the earliest next grant is the cycle
//    after.
//  - Latency: zero added cycles on request and response paths. Back-to-back
//    reads cost one idle cycle between them.
//  - mst_r_valid_i in IDLE is a protocol error: ignored, no slv_r_valid_o.
//  - Reset mid-transaction: the FSM returns to IDLE and lock and pointer
//    clear. A response in flight is discarded.
//  - NB_MASTERS=1: rr_ptr is a constant 0, behaviour otherwise identical.
// TESTING
//  1. NB=2: only req0 reads A=0x010 with gnt=1, then r_valid rdata=0xDEADBEEF
//     -> gnt_o=01, then r_valid_o=01, rdata=0xDEADBEEF, state back to IDLE.
//  2. req0 and req1 both write, gnt=1 every cycle, from reset
//     -> grants 0,1,0,1 on consecutive cycles, mst_we_o=1, no r_valid_o.
//  3. req1 reads, gnt=0 for 3 cycles, req0 rises in cycle 2
//     -> mst payload stays req1's, gnt_o=10 on cycle 4, req0 served afterwards.
//  4. req0 read outstanding, req1 write asserted -> mst_req_o=0 until
//     r_valid; req1 granted the cycle after r_valid_o[0].
//  5. Reset asserted in WAIT_RSP, then r_valid=1 after release
//     -> no slv_r_valid_o, rr_ptr=0, all outputs 0.
//  6. r_valid=1 pulsed in IDLE with no requests -> slv_r_valid_o stays 00.

Source files
------------

// File: rtl/per_master_arbiter.sv
// rtl/per_master_arbiter.sv - round-robin arbiter sharing one peripheral master port
//
// Purpose:
//   Grants one of NB_MASTERS requesters at a time onto a single shared
//   peripheral port. A write finishes at the grant handshake. A read keeps
//   the arbiter busy until the response valid returns, and that response is
//   steered back to the requester that issued it. All outputs are
//   combinational from the current state and the inputs, so neither the
//   request path nor the response path adds a cycle.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   slv_req_i   [NB]            per-requester request
//   slv_add_i   [NB*AW]         requester i address at [i*AW +: AW]
//   slv_we_i    [NB]            1 = write, 0 = read
//   slv_wdata_i [NB*32]         requester i write data at [i*32 +: 32]
//   slv_be_i    [NB*4]          requester i byte enables at [i*4 +: 4]
//   slv_gnt_o   [NB]            per-requester grant
//   slv_r_valid_o [NB]          per-requester read response valid
//   slv_r_opc_o, slv_r_rdata_o  response opcode/data, broadcast to all requesters
//   mst_req_o, mst_add_o, mst_we_o, mst_wdata_o, mst_be_o   shared port request
//   mst_gnt_i                   shared port grant
//   mst_r_valid_i, mst_r_opc_i, mst_r_rdata_i               shared port response

module per_master_arbiter #(
    parameter int NB_MASTERS = 2,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,

    input  logic [NB_MASTERS-1:0]          slv_req_i,
    input  logic [NB_MASTERS*ADDR_WIDTH-1:0] slv_add_i,
    input  logic [NB_MASTERS-1:0]          slv_we_i,
    input  logic [NB_MASTERS*32-1:0]       slv_wdata_i,
    input  logic [NB_MASTERS*4-1:0]        slv_be_i,
    output logic [NB_MASTERS-1:0]          slv_gnt_o,
    output logic [NB_MASTERS-1:0]          slv_r_valid_o,
    output logic                           slv_r_opc_o,
    output logic [31:0]                    slv_r_rdata_o,

    output logic                           mst_req_o,
    output logic [ADDR_WIDTH-1:0]          mst_add_o,
    output logic                           mst_we_o,
    output logic [31:0]                    mst_wdata_o,
    output logic [3:0]                     mst_be_o,
    input  logic                           mst_gnt_i,
    input  logic                           mst_r_valid_i,
    input  logic                           mst_r_opc_i,
    input  logic [31:0]                    mst_r_rdata_i
);

    localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;

    logic              found;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  winner_inc;
    logic [IDX_W-1:0]  cand;
    int                scan_idx;

    // Winner selection. A locked request (presented but not yet granted by
    // the shared port) keeps ownership so the payload on mst_* cannot change
    // underneath the downstream slave.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        scan_idx = 0;
        if (lock_q) begin
            found  = 1'b1;
            winner = lock_idx_q;
        end else begin
            for (int k = 0; k < NB_MASTERS; k++) begin
                scan_idx = (int'(rr_ptr_q) + k) % NB_MASTERS;
                cand     = IDX_W'(scan_idx);
                if (!found && slv_req_i[cand]) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    // Pointer advance with wrap; with a single requester this is always 0.
    always_comb begin
        if (winner == IDX_W'(NB_MASTERS - 1)) begin
            winner_inc = '0;
        end else begin
            winner_inc = winner + IDX_W'(1);
        end
    end

    // Response opcode/data are broadcast; only the valid is steered.
    assign slv_r_opc_o   = mst_r_opc_i;
    assign slv_r_rdata_o = mst_r_rdata_i;

    always_comb begin
        mst_req_o     = 1'b0;
        mst_add_o     = '0;
        mst_we_o      = 1'b0;
        mst_wdata_o   = '0;
        mst_be_o      = '0;
        slv_gnt_o     = '0;
        slv_r_valid_o = '0;
        if (state_q == IDLE) begin
            if (found) begin
                mst_req_o         = 1'b1;
                mst_add_o         = slv_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
                mst_we_o          = slv_we_i[winner];
                mst_wdata_o       = slv_wdata_i[winner*32 +: 32];
                mst_be_o          = slv_be_i[winner*4 +: 4];
                slv_gnt_o[winner] = mst_gnt_i;
            end
            // A response valid seen in IDLE has no owner and is dropped.
        end else begin
            slv_r_valid_o[rsp_idx_q] = mst_r_valid_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rsp_idx_d  = rsp_idx_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    if (mst_gnt_i) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = winner_inc;
                        if (!slv_we_i[winner]) begin
                            rsp_idx_d = winner;
                            state_d   = WAIT_RSP;
                        end
                    end else begin
                        lock_d     = 1'b1;
                        lock_idx_d = winner;
                    end
                end
            end
            WAIT_RSP: begin
                // No new grant in the response cycle; arbitration resumes
                // on the following cycle.
                if (mst_r_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rsp_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rsp_idx_q  <= rsp_idx_d;
        end
    end

endmodule

// File: tb/tb_per_master_arbiter.sv
// tb/tb_per_master_arbiter.sv - self-checking bench for per_master_arbiter

module tb_per_master_arbiter;

    localparam int NB = 2;
    localparam int AW = 15;

    logic            clk;
    logic            rst_n;
    logic [NB-1:0]   req;
    logic [NB*AW-1:0] add;
    logic [NB-1:0]   we;
    logic [NB*32-1:0] wdata;
    logic [NB*4-1:0] be;
    logic [NB-1:0]   gnt_o;
    logic [NB-1:0]   rv_o;
    logic            r_opc_o;
    logic [31:0]     rdata_o;
    logic            mst_req;
    logic [AW-1:0]   mst_add;
    logic            mst_we;
    logic [31:0]     mst_wdata;
    logic [3:0]      mst_be;
    logic            mst_gnt;
    logic            mst_rv;
    logic            mst_opc;
    logic [31:0]     mst_rdata;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } rsp_t;

    rsp_t rsp_q[$];
    int   gnt_q[$];
    int   total;
    int   bad;

    per_master_arbiter #(.NB_MASTERS(NB), .ADDR_WIDTH(AW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .slv_req_i     (req),
        .slv_add_i     (add),
        .slv_we_i      (we),
        .slv_wdata_i   (wdata),
        .slv_be_i      (be),
        .slv_gnt_o     (gnt_o),
        .slv_r_valid_o (rv_o),
        .slv_r_opc_o   (r_opc_o),
        .slv_r_rdata_o (rdata_o),
        .mst_req_o     (mst_req),
        .mst_add_o     (mst_add),
        .mst_we_o      (mst_we),
        .mst_wdata_o   (mst_wdata),
        .mst_be_o      (mst_be),
        .mst_gnt_i     (mst_gnt),
        .mst_r_valid_i (mst_rv),
        .mst_r_opc_i   (mst_opc),
        .mst_r_rdata_i (mst_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic set_m(input int i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        req[i]          = r;
        we[i]           = w;
        add[i*AW +: AW] = a;
        wdata[i*32 +: 32] = d;
        be[i*4 +: 4]    = b;
    endtask

    task automatic clear_inputs();
        req       = '0;
        add       = '0;
        we        = '0;
        wdata     = '0;
        be        = '0;
        mst_gnt   = 1'b0;
        mst_rv    = 1'b0;
        mst_opc   = 1'b0;
        mst_rdata = '0;
    endtask

    task automatic pulse_reset();
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rsp_t e;
        clear_inputs();
        rst_n  = 1'b0;
        mst_rv = 1'b1;
        tick();
        settle();
        total++;
        if (mst_req !== 1'b0 || gnt_o !== 2'b00 || rv_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_during: req=%b gnt=%b rv=%b required 0/00/00", mst_req, gnt_o, rv_o);
        end
        total++;
        if (mst_add !== '0 || mst_we !== 1'b0 || mst_wdata !== '0 || mst_be !== '0) begin
            bad++;
            $display("FAIL reset_payload: add=%h we=%b wd=%h be=%h required zeros", mst_add, mst_we, mst_wdata, mst_be);
        end
        tick();
        rst_n  = 1'b1;
        mst_rv = 1'b0;
        settle();
        total++;
        if (dut.rr_ptr_q !== 1'b0 || dut.lock_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs: rr_ptr=%b lock=%b required 0/0", dut.rr_ptr_q, dut.lock_q);
        end
        total++;
        if (mst_req !== 1'b0 || gnt_o !== 2'b00 || rv_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_after: req=%b gnt=%b rv=%b required 0/00/00", mst_req, gnt_o, rv_o);
        end
        e.idx = 0;
        e.data = '0;
        rsp_q.delete();
    endtask

    task automatic test_single_read();
        rsp_t e;
        tick();
        set_m(0, 1'b1, 1'b0, 15'h010, 32'h0, 4'hF);
        mst_gnt = 1'b1;
        settle();
        total++;
        if (mst_req !== 1'b1 || mst_add !== 15'h010 || mst_we !== 1'b0 || mst_be !== 4'hF || gnt_o !== 2'b01) begin
            bad++;
            $display("FAIL rd_grant: req=%b add=%h we=%b be=%h gnt=%b required 1/010/0/f/01",
                     mst_req, mst_add, mst_we, mst_be, gnt_o);
        end
        e.idx = 0;
        e.data = 32'hDEADBEEF;
        rsp_q.push_back(e);
        tick();
        set_m(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        mst_gnt = 1'b0;
        settle();
        total++;
        if (mst_req !== 1'b0 || rv_o !== 2'b00) begin
            bad++;
            $display("FAIL rd_wait: req=%b rv=%b required 0/00", mst_req, rv_o);
        end
        tick();
        mst_rv    = 1'b1;
        mst_rdata = 32'hDEADBEEF;
        settle();
        if (rsp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_rsp: response seen with empty scoreboard");
        end else begin
            e = rsp_q.pop_front();
            total++;
            if (rv_o !== 2'(1 << e.idx) || rdata_o !== e.data) begin
                bad++;
                $display("FAIL rd_rsp: rv=%b rdata=%h required %b/%h", rv_o, rdata_o, 2'(1 << e.idx), e.data);
            end
        end
        tick();
        mst_rv = 1'b0;
        // A fresh write must be granted at once, showing the FSM is back in IDLE.
        set_m(1, 1'b1, 1'b1, 15'h7FF, 32'h1, 4'h3);
        mst_gnt = 1'b1;
        settle();
        total++;
        if (gnt_o !== 2'b10 || rv_o !== 2'b00 || mst_add !== 15'h7FF) begin
            bad++;
            $display("FAIL rd_back_idle: gnt=%b rv=%b add=%h required 10/00/7ff", gnt_o, rv_o, mst_add);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_rr_writes();
        int e;
        clear_inputs();
        pulse_reset();
        tick();
        set_m(0, 1'b1, 1'b1, 15'h100, 32'hA0A0A0A0, 4'hF);
        set_m(1, 1'b1, 1'b1, 15'h200, 32'hB1B1B1B1, 4'h5);
        mst_gnt = 1'b1;
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        for (int c = 0; c < 4; c++) begin
            if (c != 0) tick();
            settle();
            e = gnt_q.pop_front();
            total++;
            if (gnt_o !== 2'(1 << e) || mst_we !== 1'b1 || rv_o !== 2'b00 ||
                mst_add !== ((e == 1) ? 15'h200 : 15'h100) ||
                mst_wdata !== ((e == 1) ? 32'hB1B1B1B1 : 32'hA0A0A0A0)) begin
                bad++;
                $display("FAIL rr_write_%0d: gnt=%b we=%b rv=%b add=%h wd=%h required grant to %0d",
                         c, gnt_o, mst_we, rv_o, mst_add, mst_wdata, e);
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_hold();
        rsp_t e;
        // rr_ptr is 0 here; lock must keep requester 1 even after req0 rises.
        tick();
        set_m(1, 1'b1, 1'b0, 15'h055, 32'h0, 4'hC);
        mst_gnt = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c != 1) tick();
            if (c == 2) set_m(0, 1'b1, 1'b1, 15'h0AA, 32'h600D600D, 4'hF);
            settle();
            total++;
            if (mst_req !== 1'b1 || mst_add !== 15'h055 || mst_we !== 1'b0 || mst_be !== 4'hC || gnt_o !== 2'b00) begin
                bad++;
                $display("FAIL hold_c%0d: req=%b add=%h we=%b be=%h gnt=%b required 1/055/0/c/00",
                         c, mst_req, mst_add, mst_we, mst_be, gnt_o);
            end
        end
        tick();
        mst_gnt = 1'b1;
        settle();
        total++;
        if (gnt_o !== 2'b10 || mst_add !== 15'h055) begin
            bad++;
            $display("FAIL hold_grant: gnt=%b add=%h required 10/055", gnt_o, mst_add);
        end
        e.idx = 1;
        e.data = 32'h12345678;
        rsp_q.push_back(e);
        tick();
        set_m(1, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        mst_rv    = 1'b1;
        mst_rdata = 32'h12345678;
        settle();
        e = rsp_q.pop_front();
        total++;
        if (rv_o !== 2'(1 << e.idx) || rdata_o !== e.data || gnt_o !== 2'b00 || mst_req !== 1'b0) begin
            bad++;
            $display("FAIL hold_rsp: rv=%b rdata=%h gnt=%b req=%b required %b/%h/00/0",
                     rv_o, rdata_o, gnt_o, mst_req, 2'(1 << e.idx), e.data);
        end
        tick();
        mst_rv = 1'b0;
        settle();
        total++;
        if (gnt_o !== 2'b01 || mst_add !== 15'h0AA || mst_we !== 1'b1 || mst_wdata !== 32'h600D600D) begin
            bad++;
            $display("FAIL hold_next: gnt=%b add=%h we=%b wd=%h required 01/0aa/1/600d600d",
                     gnt_o, mst_add, mst_we, mst_wdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_read_blocks();
        rsp_t e;
        // rr_ptr is 1 here; requester 0 is the only one asking.
        tick();
        set_m(0, 1'b1, 1'b0, 15'h321, 32'h0, 4'hF);
        mst_gnt = 1'b1;
        settle();
        total++;
        if (gnt_o !== 2'b01 || mst_add !== 15'h321) begin
            bad++;
            $display("FAIL blk_grant: gnt=%b add=%h required 01/321", gnt_o, mst_add);
        end
        e.idx = 0;
        e.data = 32'hCAFEF00D;
        rsp_q.push_back(e);
        tick();
        set_m(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        set_m(1, 1'b1, 1'b1, 15'h444, 32'h55AA55AA, 4'hF);
        for (int c = 0; c < 2; c++) begin
            if (c != 0) tick();
            settle();
            total++;
            if (mst_req !== 1'b0 || gnt_o !== 2'b00 || mst_add !== '0) begin
                bad++;
                $display("FAIL blk_wait_%0d: req=%b gnt=%b add=%h required 0/00/0", c, mst_req, gnt_o, mst_add);
            end
        end
        tick();
        mst_rv    = 1'b1;
        mst_rdata = 32'hCAFEF00D;
        settle();
        e = rsp_q.pop_front();
        total++;
        if (rv_o !== 2'(1 << e.idx) || rdata_o !== e.data || gnt_o !== 2'b00 || mst_req !== 1'b0) begin
            bad++;
            $display("FAIL blk_rsp: rv=%b rdata=%h gnt=%b req=%b required %b/%h/00/0",
                     rv_o, rdata_o, gnt_o, mst_req, 2'(1 << e.idx), e.data);
        end
        tick();
        mst_rv = 1'b0;
        settle();
        total++;
        if (gnt_o !== 2'b10 || mst_req !== 1'b1 || mst_add !== 15'h444 || mst_we !== 1'b1 || rv_o !== 2'b00) begin
            bad++;
            $display("FAIL blk_next: gnt=%b req=%b add=%h we=%b rv=%b required 10/1/444/1/00",
                     gnt_o, mst_req, mst_add, mst_we, rv_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        // rr_ptr is 0; a read from requester 0 moves it to 1 before reset.
        tick();
        set_m(0, 1'b1, 1'b0, 15'h0F0, 32'h0, 4'hF);
        mst_gnt = 1'b1;
        tick();
        clear_inputs();
        settle();
        total++;
        if (mst_req !== 1'b0 || dut.rr_ptr_q !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait: req=%b rr_ptr=%b required 0/1", mst_req, dut.rr_ptr_q);
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        mst_rv    = 1'b1;
        mst_rdata = 32'hBAADF00D;
        settle();
        total++;
        if (rv_o !== 2'b00 || dut.rr_ptr_q !== 1'b0 || dut.lock_q !== 1'b0) begin
            bad++;
            $display("FAIL mid_rsp: rv=%b rr_ptr=%b lock=%b required 00/0/0", rv_o, dut.rr_ptr_q, dut.lock_q);
        end
        total++;
        if (mst_req !== 1'b0 || gnt_o !== 2'b00 || mst_add !== '0 || mst_wdata !== '0 || mst_be !== '0) begin
            bad++;
            $display("FAIL mid_outs: req=%b gnt=%b add=%h wd=%h be=%h required zeros",
                     mst_req, gnt_o, mst_add, mst_wdata, mst_be);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_stray_rvalid();
        tick();
        mst_rv    = 1'b1;
        mst_rdata = 32'h0BADCAFE;
        for (int c = 0; c < 2; c++) begin
            if (c != 0) tick();
            settle();
            total++;
            if (rv_o !== 2'b00 || mst_req !== 1'b0 || gnt_o !== 2'b00) begin
                bad++;
                $display("FAIL stray_%0d: rv=%b req=%b gnt=%b required 00/0/00", c, rv_o, mst_req, gnt_o);
            end
        end
        tick();
        clear_inputs();
        settle();
        total++;
        if (rsp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: pending=%0d required 0", rsp_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_rr_writes();
        test_hold();
        test_read_blocks();
        test_reset_mid();
        test_stray_rvalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
